// File: rtl/uart_rx_core_if.sv
// Consumer-side handshake between the UART receive core and the register block.
// The core drives the holding register and flags; the consumer returns the read strobe.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: line synchroniser, start-bit validation, mid-bit sampling
// and a one-entry holding register with valid/ack, framing and overrun flags.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk_in,
    input  logic           sys_rstn,
    input  logic           uart_rxd,
    uart_rx_core_if.master rx_if
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] H_LAST = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] B_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               rxd_s_q, rxd_s_d;
    logic               rxd_d_q, rxd_d_d;
    logic [1:0]         fill_q, fill_d;
    logic               armed_q, armed_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               deliver_q, deliver_d;
    logic               ferr_pend_q, ferr_pend_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               overrun_q, overrun_d;
    logic               frame_err_q, frame_err_d;
    logic               fell;

    // The synchroniser resets to 1, so a line that is low at release would look
    // like a falling edge; start detection stays disarmed until a genuine high.
    assign fell = armed_q & rxd_d_q & ~rxd_s_q;

    always_comb begin
        sync1_d     = uart_rxd;
        rxd_s_d     = sync1_q;
        rxd_d_d     = rxd_s_q;
        fill_d      = fill_q[1] ? fill_q : fill_q + 2'd1;
        armed_d     = armed_q | (fill_q[1] & rxd_s_q);
        state_d     = state_q;
        div_d       = div_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        ferr_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fell) begin
                    div_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_q == H_LAST) begin
                    div_d = '0;
                    idx_d = '0;
                    state_d = rxd_s_q ? S_IDLE : S_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DATA: begin
                if (div_q == B_LAST) begin
                    div_d          = '0;
                    shift_d[idx_q] = rxd_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STOP: begin
                if (div_q == B_LAST) begin
                    div_d = '0;
                    if (rxd_s_q) begin
                        deliver_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_pend_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register updates one edge after the stop sample.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = ferr_pend_q;
        if (deliver_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_if.rx_ack) overrun_d = 1'b1;
        end else if (rx_if.rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_d_q     <= 1'b1;
            fill_q      <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= S_IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            ferr_pend_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxd_s_q     <= rxd_s_d;
            rxd_d_q     <= rxd_d_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            ferr_pend_q <= ferr_pend_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.overrun   = overrun_q;
    assign rx_if.frame_err = frame_err_q;

endmodule
